// File: rtl/control_unit.sv
// control_unit: main decode/control unit of the 5-stage RV32I pipeline (decode stage).
// Maps the pre-decoded instruction identifier to the datapath control signals.
//
// Packages (kept in this file so the block stays self-contained):
//   opcodes_pkg       - opcode_out_t, the pre-decoded instruction identifier
//   control_types_pkg - enums for every multi-bit control output
//
// Parameters:
//   REGISTER_OUT  0: outputs follow opcode_in combinationally
//                 1: outputs registered on clk (one-cycle latency)
// Ports:
//   clk                in   clock (outputs only depend on it when REGISTER_OUT=1)
//   rst                in   synchronous active-high reset; forces NOP decode
//   opcode_in          in   decoded instruction identifier
//   reg_do_write_ctrl  out  register-file write enable
//   mem_do_write_ctrl  out  data-memory write enable
//   mem_do_read_ctrl   out  data-memory read enable
//   do_branch          out  conditional branch instruction
//   do_jump            out  unconditional jump (JAL/JALR)
//   comp_ctrl          out  branch comparator op
//   reg_wr_src_ctrl    out  write-back mux select
//   alu_op1_ctrl       out  ALU operand 1 select
//   alu_op2_ctrl       out  ALU operand 2 select
//   alu_ctrl           out  ALU operation
//   mem_ctrl           out  memory access size/sign

package opcodes_pkg;
    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR,
        OP_LUI, OP_AUIPC
    } opcode_out_t;
endpackage

package control_types_pkg;
    typedef enum logic [2:0] {
        BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } comp_op_t;

    typedef enum logic [1:0] {
        WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PC4
    } reg_wr_src_t;

    typedef enum logic {
        SRC1_REG1, SRC1_PC
    } alu_src1_t;

    typedef enum logic {
        SRC2_REG2, SRC2_IMM
    } alu_src2_t;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
    } alu_op_t;

    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_ctrl_t;
endpackage

module control_unit
    import opcodes_pkg::*;
    import control_types_pkg::*;
#(
    parameter int unsigned REGISTER_OUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  opcode_out_t opcode_in,
    output logic        reg_do_write_ctrl,
    output logic        mem_do_write_ctrl,
    output logic        mem_do_read_ctrl,
    output logic        do_branch,
    output logic        do_jump,
    output comp_op_t    comp_ctrl,
    output reg_wr_src_t reg_wr_src_ctrl,
    output alu_src1_t   alu_op1_ctrl,
    output alu_src2_t   alu_op2_ctrl,
    output alu_op_t     alu_ctrl,
    output mem_ctrl_t   mem_ctrl
);

    typedef struct packed {
        logic        reg_wr;
        logic        mem_wr;
        logic        mem_rd;
        logic        branch;
        logic        jump;
        comp_op_t    comp;
        reg_wr_src_t wr_src;
        alu_src1_t   src1;
        alu_src2_t   src2;
        alu_op_t     alu;
        mem_ctrl_t   mem;
    } ctrl_t;

    localparam ctrl_t NOP_DECODE = '{
        reg_wr: 1'b0, mem_wr: 1'b0, mem_rd: 1'b0, branch: 1'b0, jump: 1'b0,
        comp: BR_NOP, wr_src: WRSRC_ALURES, src1: SRC1_REG1, src2: SRC2_REG2,
        alu: ALU_NOP, mem: MEM_NOP
    };

    alu_op_t   base_alu;
    mem_ctrl_t base_mem;
    comp_op_t  base_comp;
    ctrl_t     ctrl_d;
    ctrl_t     ctrl_q;
    ctrl_t     ctrl_out;

    // Per-instruction sub-fields, shared by the class decode below so that
    // R-type and I-type variants of the same operation map to one ALU op.
    always_comb begin
        base_alu  = ALU_NOP;
        base_mem  = MEM_NOP;
        base_comp = BR_NOP;
        case (opcode_in)
            OP_ADD,  OP_ADDI:  base_alu = ALU_ADD;
            OP_SUB:            base_alu = ALU_SUB;
            OP_SLL,  OP_SLLI:  base_alu = ALU_SLL;
            OP_SLT,  OP_SLTI:  base_alu = ALU_SLT;
            OP_SLTU, OP_SLTIU: base_alu = ALU_SLTU;
            OP_XOR,  OP_XORI:  base_alu = ALU_XOR;
            OP_SRL,  OP_SRLI:  base_alu = ALU_SRL;
            OP_SRA,  OP_SRAI:  base_alu = ALU_SRA;
            OP_OR,   OP_ORI:   base_alu = ALU_OR;
            OP_AND,  OP_ANDI:  base_alu = ALU_AND;
            OP_LB:             base_mem = MEM_LB;
            OP_LH:             base_mem = MEM_LH;
            OP_LW:             base_mem = MEM_LW;
            OP_LBU:            base_mem = MEM_LBU;
            OP_LHU:            base_mem = MEM_LHU;
            OP_SB:             base_mem = MEM_SB;
            OP_SH:             base_mem = MEM_SH;
            OP_SW:             base_mem = MEM_SW;
            OP_BEQ:            base_comp = BR_EQ;
            OP_BNE:            base_comp = BR_NE;
            OP_BLT:            base_comp = BR_LT;
            OP_BGE:            base_comp = BR_GE;
            OP_BLTU:           base_comp = BR_LTU;
            OP_BGEU:           base_comp = BR_GEU;
            default: ;
        endcase
    end

    // Class decode; anything not listed (including illegal encodings) stays NOP.
    always_comb begin
        ctrl_d = NOP_DECODE;
        case (opcode_in)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.src2   = SRC2_REG2;
                ctrl_d.alu    = base_alu;
            end
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
            OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = base_alu;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.mem_rd = 1'b1;
                ctrl_d.wr_src = WRSRC_MEMREAD;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_ADD;
                ctrl_d.mem    = base_mem;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_d.mem_wr = 1'b1;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_ADD;
                ctrl_d.mem    = base_mem;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                // ALU forms the branch target; the comparator decides taken.
                ctrl_d.branch = 1'b1;
                ctrl_d.comp   = base_comp;
                ctrl_d.src1   = SRC1_PC;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_ADD;
            end
            OP_JAL: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.jump   = 1'b1;
                ctrl_d.wr_src = WRSRC_PC4;
                ctrl_d.src1   = SRC1_PC;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_ADD;
            end
            OP_JALR: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.jump   = 1'b1;
                ctrl_d.wr_src = WRSRC_PC4;
                ctrl_d.src1   = SRC1_REG1;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_ADD;
            end
            OP_LUI: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_LUI;
            end
            OP_AUIPC: begin
                ctrl_d.reg_wr = 1'b1;
                ctrl_d.src1   = SRC1_PC;
                ctrl_d.src2   = SRC2_IMM;
                ctrl_d.alu    = ALU_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= NOP_DECODE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // The register always exists; with REGISTER_OUT=0 it is simply unobserved
    // and removed by synthesis.
    always_comb begin
        if (REGISTER_OUT != 0) begin
            ctrl_out = ctrl_q;
        end else if (rst) begin
            ctrl_out = NOP_DECODE;
        end else begin
            ctrl_out = ctrl_d;
        end
    end

    assign reg_do_write_ctrl = ctrl_out.reg_wr;
    assign mem_do_write_ctrl = ctrl_out.mem_wr;
    assign mem_do_read_ctrl  = ctrl_out.mem_rd;
    assign do_branch         = ctrl_out.branch;
    assign do_jump           = ctrl_out.jump;
    assign comp_ctrl         = ctrl_out.comp;
    assign reg_wr_src_ctrl   = ctrl_out.wr_src;
    assign alu_op1_ctrl      = ctrl_out.src1;
    assign alu_op2_ctrl      = ctrl_out.src2;
    assign alu_ctrl          = ctrl_out.alu;
    assign mem_ctrl          = ctrl_out.mem;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: checks a combinational (REGISTER_OUT=0) and a registered
// (REGISTER_OUT=1) instance of control_unit, driven by the same stimulus,
// against a table-driven model of the decode rules.
module tb_control_unit;
    import opcodes_pkg::*;
    import control_types_pkg::*;

    typedef struct packed {
        logic        reg_wr;
        logic        mem_wr;
        logic        mem_rd;
        logic        branch;
        logic        jump;
        comp_op_t    comp;
        reg_wr_src_t wr_src;
        alu_src1_t   src1;
        alu_src2_t   src2;
        alu_op_t     alu;
        mem_ctrl_t   mem;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    opcode_out_t opcode;

    logic        c_reg_wr, c_mem_wr, c_mem_rd, c_br, c_jmp;
    comp_op_t    c_comp;
    reg_wr_src_t c_wrsrc;
    alu_src1_t   c_src1;
    alu_src2_t   c_src2;
    alu_op_t     c_alu;
    mem_ctrl_t   c_mem;

    logic        r_reg_wr, r_mem_wr, r_mem_rd, r_br, r_jmp;
    comp_op_t    r_comp;
    reg_wr_src_t r_wrsrc;
    alu_src1_t   r_src1;
    alu_src2_t   r_src2;
    alu_op_t     r_alu;
    mem_ctrl_t   r_mem;

    always #5 clk = ~clk;

    control_unit #(.REGISTER_OUT(0)) u_comb (
        .clk(clk), .rst(rst), .opcode_in(opcode),
        .reg_do_write_ctrl(c_reg_wr), .mem_do_write_ctrl(c_mem_wr),
        .mem_do_read_ctrl(c_mem_rd), .do_branch(c_br), .do_jump(c_jmp),
        .comp_ctrl(c_comp), .reg_wr_src_ctrl(c_wrsrc), .alu_op1_ctrl(c_src1),
        .alu_op2_ctrl(c_src2), .alu_ctrl(c_alu), .mem_ctrl(c_mem)
    );

    control_unit #(.REGISTER_OUT(1)) u_reg (
        .clk(clk), .rst(rst), .opcode_in(opcode),
        .reg_do_write_ctrl(r_reg_wr), .mem_do_write_ctrl(r_mem_wr),
        .mem_do_read_ctrl(r_mem_rd), .do_branch(r_br), .do_jump(r_jmp),
        .comp_ctrl(r_comp), .reg_wr_src_ctrl(r_wrsrc), .alu_op1_ctrl(r_src1),
        .alu_op2_ctrl(r_src2), .alu_ctrl(r_alu), .mem_ctrl(r_mem)
    );

    exp_t act_c, act_r;
    assign act_c = {c_reg_wr, c_mem_wr, c_mem_rd, c_br, c_jmp, c_comp, c_wrsrc,
                    c_src1, c_src2, c_alu, c_mem};
    assign act_r = {r_reg_wr, r_mem_wr, r_mem_rd, r_br, r_jmp, r_comp, r_wrsrc,
                    r_src1, r_src2, r_alu, r_mem};

    // Instruction class tables: each opcode paired with its operation.
    opcode_out_t r_ops [10] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                                OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
    alu_op_t     r_alus[10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                                ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
    opcode_out_t i_ops [9]  = '{OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                                OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
    alu_op_t     i_alus[9]  = '{ALU_ADD, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR,
                                ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA};
    opcode_out_t ld_ops[5]  = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    mem_ctrl_t   ld_mem[5]  = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    opcode_out_t st_ops[3]  = '{OP_SB, OP_SH, OP_SW};
    mem_ctrl_t   st_mem[3]  = '{MEM_SB, MEM_SH, MEM_SW};
    opcode_out_t br_ops[6]  = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    comp_op_t    br_cmp[6]  = '{BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};

    function automatic exp_t mk(logic wr, logic mw, logic mr, logic br, logic jp,
                                comp_op_t cp, reg_wr_src_t ws, alu_src1_t s1,
                                alu_src2_t s2, alu_op_t al, mem_ctrl_t me);
        exp_t e;
        e = {wr, mw, mr, br, jp, cp, ws, s1, s2, al, me};
        return e;
    endfunction

    function automatic exp_t model(opcode_out_t op, logic r);
        exp_t e;
        e = mk(0, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_REG2, ALU_NOP, MEM_NOP);
        if (r) return e;
        foreach (r_ops[i]) if (op == r_ops[i])
            e = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_REG2, r_alus[i], MEM_NOP);
        foreach (i_ops[i]) if (op == i_ops[i])
            e = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_IMM, i_alus[i], MEM_NOP);
        foreach (ld_ops[i]) if (op == ld_ops[i])
            e = mk(1, 0, 1, 0, 0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM, ALU_ADD, ld_mem[i]);
        foreach (st_ops[i]) if (op == st_ops[i])
            e = mk(0, 1, 0, 0, 0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_IMM, ALU_ADD, st_mem[i]);
        foreach (br_ops[i]) if (op == br_ops[i])
            e = mk(0, 0, 0, 1, 0, br_cmp[i], WRSRC_ALURES, SRC1_PC, SRC2_IMM, ALU_ADD, MEM_NOP);
        if (op == OP_JAL)
            e = mk(1, 0, 0, 0, 1, BR_NOP, WRSRC_PC4, SRC1_PC, SRC2_IMM, ALU_ADD, MEM_NOP);
        if (op == OP_JALR)
            e = mk(1, 0, 0, 0, 1, BR_NOP, WRSRC_PC4, SRC1_REG1, SRC2_IMM, ALU_ADD, MEM_NOP);
        if (op == OP_LUI)
            e = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES, SRC1_REG1, SRC2_IMM, ALU_LUI, MEM_NOP);
        if (op == OP_AUIPC)
            e = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES, SRC1_PC, SRC2_IMM, ALU_ADD, MEM_NOP);
        return e;
    endfunction

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: op=%0d rst=%0b got %h expected %h",
                      name, opcode, rst, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: op=%0d rst=%0b got %0b expected %0b",
                      name, opcode, rst, act, exp);
    endtask

    // Expected registered outputs: what the model says for the inputs present at each posedge.
    exp_t exp_reg;
    logic reg_valid = 1'b0;
    always @(posedge clk) begin
        exp_reg   <= model(opcode, rst);
        reg_valid <= 1'b1;
    end

    // Compare process: both instances against the model, plus output invariants.
    always @(negedge clk) begin
        check("comb_decode", act_c, model(opcode, rst));
        check_bit("comb_rd_wr_excl", act_c.mem_rd & act_c.mem_wr, 1'b0);
        check_bit("comb_br_jmp_excl", act_c.branch & act_c.jump, 1'b0);
        check_bit("comb_rd_iff_memsrc", act_c.mem_rd, act_c.wr_src == WRSRC_MEMREAD);
        if (reg_valid) begin
            check("reg_decode", act_r, exp_reg);
            check_bit("reg_rd_wr_excl", act_r.mem_rd & act_r.mem_wr, 1'b0);
            check_bit("reg_br_jmp_excl", act_r.branch & act_r.jump, 1'b0);
            check_bit("reg_rd_iff_memsrc", act_r.mem_rd, act_r.wr_src == WRSRC_MEMREAD);
        end
    end

    task automatic drive(input logic r, input opcode_out_t op);
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
    endtask

    exp_t lit_nop, lit_add, lit_addi, lit_lw, lit_sw, lit_beq, lit_jal, lit_lui;

    initial begin
        lit_nop  = mk(0, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_NOP, MEM_NOP);
        lit_add  = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_REG2, ALU_ADD, MEM_NOP);
        lit_addi = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_ADD, MEM_NOP);
        lit_lw   = mk(1, 0, 1, 0, 0, BR_NOP, WRSRC_MEMREAD, SRC1_REG1, SRC2_IMM,  ALU_ADD, MEM_LW);
        lit_sw   = mk(0, 1, 0, 0, 0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_ADD, MEM_SW);
        lit_beq  = mk(0, 0, 0, 1, 0, BR_EQ,  WRSRC_ALURES,  SRC1_PC,   SRC2_IMM,  ALU_ADD, MEM_NOP);
        lit_jal  = mk(1, 0, 0, 0, 1, BR_NOP, WRSRC_PC4,     SRC1_PC,   SRC2_IMM,  ALU_ADD, MEM_NOP);
        lit_lui  = mk(1, 0, 0, 0, 0, BR_NOP, WRSRC_ALURES,  SRC1_REG1, SRC2_IMM,  ALU_LUI, MEM_NOP);

        rst    = 1'b1;
        opcode = OP_ADD;
        #1 check("lit_comb_rst_add", act_c, lit_nop);
        drive(1, OP_JAL);
        #1 check("lit_reg_after_rst", act_r, lit_nop);

        // Hand-computed decodes on the combinational instance.
        drive(0, OP_ADD);   #1 check("lit_add",   act_c, lit_add);
        drive(0, OP_ADDI);  #1 check("lit_addi",  act_c, lit_addi);
        drive(0, OP_LW);    #1 check("lit_lw",    act_c, lit_lw);
        drive(0, OP_SW);    #1 check("lit_sw",    act_c, lit_sw);
        drive(0, OP_BEQ);   #1 check("lit_beq",   act_c, lit_beq);
        drive(0, OP_JAL);   #1 check("lit_jal",   act_c, lit_jal);
        drive(0, OP_LUI);   #1 check("lit_lui",   act_c, lit_lui);
        drive(0, OP_NOP);   #1 check("lit_nop",   act_c, lit_nop);
        drive(0, opcode_out_t'(6'd63)); #1 check("lit_illegal", act_c, lit_nop);

        // Registered latency: new opcode only visible after the next posedge.
        drive(0, OP_NOP);
        drive(0, OP_LW);
        #1 check("lit_reg_before_edge", act_r, lit_nop);
        @(posedge clk);
        #1 check("lit_reg_after_edge", act_r, lit_lw);

        // Reset mid-stream discards the pending decode.
        drive(0, OP_SW);
        drive(1, OP_JAL);
        #1 check("lit_reg_pending_sw", act_r, lit_sw);
        @(posedge clk);
        #1 check("lit_reg_rst_discard", act_r, lit_nop);

        // Every encoding, legal and illegal, with and without reset.
        for (int unsigned k = 0; k < 64; k++) drive(0, opcode_out_t'(k[5:0]));
        for (int unsigned k = 0; k < 64; k++) drive(1, opcode_out_t'(k[5:0]));

        // Random stream with occasional reset.
        for (int unsigned n = 0; n < 1500; n++)
            drive($urandom_range(0, 7) == 0, opcode_out_t'(6'($urandom_range(0, 63))));

        drive(0, OP_NOP);
        drive(0, OP_NOP);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
